// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Latches the winner's byte, launches it, then tracks tx_busy to report done or timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [NUM_REQ-1:0]            done,
   output logic                          tx_enable,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]    owner,
   output logic                          arb_busy,
   output logic                          timeout_err
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [15:0] TMO = 16'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      last_grant;
   logic [IDX_W-1:0]      winner;
   logic [IDX_W-1:0]      cand;
   logic                  found;
   logic [15:0]           wait_cnt;
   logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Search starts one past the last served requester so every requester gets a turn.
   always_comb begin
      winner = last_grant;
      cand   = last_grant;
      found  = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (|req && !tx_busy) state_nxt = LAUNCH;
         LAUNCH:    state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy)              state_nxt = WAIT_DONE;
            else if (wait_cnt == TMO) state_nxt = IDLE;
         end
         WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_enable   = (state == LAUNCH);
      arb_busy    = (state != IDLE);
      timeout_err = (state == WAIT_BUSY) && !tx_busy && (wait_cnt == TMO);
      ack         = '0;
      done        = '0;
      if (state == LAUNCH)                ack[owner]  = 1'b1;
      if (state == WAIT_DONE && !tx_busy) done[owner] = 1'b1;
   end

   // Grant bookkeeping; last_grant also advances on timeout so a dead requester cannot starve others.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner      <= '0;
         tx_data    <= '0;
         last_grant <= IDX_W'(NUM_REQ - 1);
         wait_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (state_nxt == LAUNCH) begin
                  owner   <= winner;
                  tx_data <= req_bytes[winner];
               end
            end
            LAUNCH: wait_cnt <= '0;
            WAIT_BUSY: begin
               if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
               if (timeout_err)          last_grant <= owner;
            end
            WAIT_DONE: if (!tx_busy) last_grant <= owner;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: transaction-level round-robin model with a
// simple UART loopback whose busy delay and length are drawn per transaction.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int DATA_WIDTH   = 8;
   localparam int BUSY_TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack;
   logic [3:0]  done;
   logic        tx_enable;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic [1:0]  owner;
   logic        arb_busy;
   logic        timeout_err;

   int n_chk = 0;
   int n_err = 0;
   int last_m = NUM_REQ - 1;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .done(done),
      .tx_enable(tx_enable), .tx_data(tx_data), .tx_busy(tx_busy), .owner(owner),
      .arb_busy(arb_busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [3:0] r);
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (((r >> ((last + i) % NUM_REQ)) & 4'd1) != 4'd0) return (last + i) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Protocol invariants hold in every cycle outside reset.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         check("inv_enable_while_busy", 32'(tx_enable & tx_busy), 32'd0);
         check("inv_ack_onehot", 32'($onehot0(ack)), 32'd1);
         check("inv_done_onehot", 32'($onehot0(done)), 32'd1);
         check("inv_ack_done_overlap", 32'((|ack) & (|done)), 32'd0);
      end
   end

   task automatic check_reset_values();
      check("rst_tx_enable", 32'(tx_enable), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_arb_busy", 32'(arb_busy), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
   endtask

   task automatic do_reset(input logic [3:0] r_hold);
      reset = 1'b0;
      req = r_hold;
      req_data = $urandom;
      #1;
      check_reset_values();
      next_cycle();
      check("rst_no_launch", 32'(tx_enable), 32'd0);
      check("rst_hold_arb_busy", 32'(arb_busy), 32'd0);
      req = '0;
      tx_busy = 1'b0;
      reset = 1'b1;
      last_m = NUM_REQ - 1;
   endtask

   task automatic txn(input logic [3:0] r, input logic [31:0] data, input int dly,
                      input int len, input bit no_busy, input logic [3:0] nxt);
      int w;
      logic [7:0] b;
      w = rr_pick(last_m, r);
      b = 8'(data >> (8 * w));
      next_cycle();
      req = r; req_data = data; tx_busy = 1'b0;
      #1;
      check("idle_arb_busy", 32'(arb_busy), 32'd0);
      check("idle_tx_enable", 32'(tx_enable), 32'd0);
      next_cycle();
      req = 4'($urandom); req_data = $urandom;
      #1;
      check("launch_tx_enable", 32'(tx_enable), 32'd1);
      check("launch_ack", 32'(ack), 32'd1 << w);
      check("launch_owner", 32'(owner), 32'(w));
      check("launch_tx_data", 32'(tx_data), 32'(b));
      check("launch_arb_busy", 32'(arb_busy), 32'd1);
      if (no_busy) begin
         for (int k = 0; k < BUSY_TIMEOUT; k++) begin
            next_cycle();
            req = 4'($urandom); req_data = $urandom;
            #1;
            check("wait_no_timeout", 32'(timeout_err), 32'd0);
            check("wait_no_enable", 32'(tx_enable), 32'd0);
         end
         next_cycle();
         req = nxt;
         #1;
         check("timeout_pulse", 32'(timeout_err), 32'd1);
         check("timeout_no_done", 32'(done), 32'd0);
         check("timeout_tx_data", 32'(tx_data), 32'(b));
      end else begin
         for (int k = 0; k < dly - 1; k++) begin
            next_cycle();
            req = 4'($urandom); req_data = $urandom;
            #1;
            check("wait_no_enable", 32'(tx_enable), 32'd0);
            check("wait_no_done", 32'(done), 32'd0);
            check("wait_no_timeout", 32'(timeout_err), 32'd0);
         end
         next_cycle();
         tx_busy = 1'b1; req_data = $urandom;
         #1;
         check("busy_rise_no_done", 32'(done), 32'd0);
         for (int k = 0; k < len; k++) begin
            next_cycle();
            req = 4'($urandom); req_data = $urandom;
            #1;
            check("busy_no_done", 32'(done), 32'd0);
            check("busy_tx_data_hold", 32'(tx_data), 32'(b));
            check("busy_arb_busy", 32'(arb_busy), 32'd1);
            check("busy_no_enable", 32'(tx_enable), 32'd0);
         end
         next_cycle();
         tx_busy = 1'b0; req = nxt; req_data = $urandom;
         #1;
         check("done_pulse", 32'(done), 32'd1 << w);
         check("done_tx_data", 32'(tx_data), 32'(b));
         check("done_no_ack", 32'(ack), 32'd0);
         check("done_no_timeout", 32'(timeout_err), 32'd0);
      end
      last_m = w;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] r_cur, r_nxt;
      reset = 1'b1;
      #1;
      do_reset(4'b0001);

      // Single request, UART busy one cycle after launch.
      txn(4'b0001, 32'h0000_00A5, 1, 2, 1'b0, 4'b1111);

      // All requesters held: rotation 0,1,2,3,0 from reset.
      next_cycle();
      do_reset(4'b0000);
      for (int i = 0; i < 5; i++) txn(4'b1111, 32'h1312_1110, 1, 1, 1'b0, 4'b1111);
      next_cycle();
      req = '0;

      // UART already busy: no launch until it goes idle.
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         req = 4'b0010; tx_busy = 1'b1;
         #1;
         check("busy_hold_no_enable", 32'(tx_enable), 32'd0);
         check("busy_hold_arb_idle", 32'(arb_busy), 32'd0);
      end
      txn(4'b0010, 32'h4433_2211, 2, 3, 1'b0, 4'b0000);

      // Busy never rises: timeout, then back to idle.
      txn(4'b0100, 32'h00C3_0000, 1, 1, 1'b1, 4'b0000);

      // Reset while waiting for tx_busy to drop.
      next_cycle();
      req = 4'b0010; req_data = 32'h0000_5A00;
      next_cycle();
      next_cycle();
      tx_busy = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      check_reset_values();
      tx_busy = 1'b0;
      #1;
      check("abort_no_done", 32'(done), 32'd0);
      do_reset(4'b1000);
      txn(4'b1000, 32'h7E00_0000, 1, 2, 1'b0, 4'b0000);

      // Random traffic; next request pattern appears in the done cycle.
      r_cur = 4'($urandom_range(1, 15));
      for (int i = 0; i < 30; i++) begin
         r_nxt = 4'($urandom_range(1, 15));
         txn(r_cur, $urandom, $urandom_range(1, 4), $urandom_range(0, 6),
             (i == 9 || i == 21), r_nxt);
         r_cur = r_nxt;
      end

      next_cycle();
      req = '0;
      next_cycle();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
